// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// Holds the controller state type, the named codes of the non-digit keys,
// and key_code(), which maps a (row, col) matrix position to its key code.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } scan_state_t;

  localparam logic [7:0] KEY_A    = 8'd10;
  localparam logic [7:0] KEY_B    = 8'd11;
  localparam logic [7:0] KEY_C    = 8'd12;
  localparam logic [7:0] KEY_D    = 8'd13;
  localparam logic [7:0] KEY_STAR = 8'd14;
  localparam logic [7:0] KEY_HASH = 8'd15;

  // Physical layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [7:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] code;
    code = 8'd0;
    case ({row, col})
      4'h0:    code = 8'd1;
      4'h1:    code = 8'd2;
      4'h2:    code = 8'd3;
      4'h3:    code = KEY_A;
      4'h4:    code = 8'd4;
      4'h5:    code = 8'd5;
      4'h6:    code = 8'd6;
      4'h7:    code = KEY_B;
      4'h8:    code = 8'd7;
      4'h9:    code = 8'd8;
      4'hA:    code = 8'd9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 8'd0;
      4'hE:    code = KEY_HASH;
      4'hF:    code = KEY_D;
      default: code = 8'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the four keypad column lines.
// Ports:
//   hwclk   - destination clock
//   reset_n - asynchronous active-low reset; both stages reset to 1 (no key)
//   raw     - column lines, asynchronous to hwclk
//   synced  - column lines after two flops, safe to use in hwclk logic
module keypad_sync (
  input  logic       hwclk,
  input  logic       reset_n,
  input  logic [3:0] raw,
  output logic [3:0] synced
);

  logic [3:0] meta_r;

  // Two-stage resynchronisation of the column lines
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 4'hF;
      synced <= 4'hF;
    end else begin
      meta_r <= raw;
      synced <= meta_r;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner with press and release debouncing.
// Drives one row low at a time, samples the synchronised columns at the end
// of each row slot, and once a contact has been stable for DEBOUNCE_CYCLES
// reports its code on key with button_pressed held high until the release
// has been equally stable.
// Ports:
//   hwclk          - system clock
//   reset_n        - asynchronous active-low reset
//   col_n          - column lines, 0 = contact closed, asynchronous
//   row_n          - registered row drive, exactly one bit low
//   key            - code of the last accepted key (kept after release)
//   button_pressed - high while the accepted key is held
module keypad_scanner #(
  parameter int SCAN_DIV        = 1200,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic       hwclk,
  input  logic       reset_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [7:0] key,
  output logic       button_pressed
);

  import keypad_pkg::*;

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  scan_state_t   state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    row_idx_r, row_idx_s;
  logic [1:0]    col_idx_r, col_idx_s;
  logic [1:0]    low_zero_s;
  logic [3:0]    row_drive_s;
  logic [7:0]    key_s;
  logic          pressed_s;
  logic          col_open_s;
  logic [3:0]    col_s;

  keypad_sync u_col_sync (
    .hwclk   (hwclk),
    .reset_n (reset_n),
    .raw     (col_n),
    .synced  (col_s)
  );

  // Lowest-numbered closed column wins when several are closed together
  always_comb begin
    low_zero_s = 2'd0;
    if (!col_s[0]) begin
      low_zero_s = 2'd0;
    end else if (!col_s[1]) begin
      low_zero_s = 2'd1;
    end else if (!col_s[2]) begin
      low_zero_s = 2'd2;
    end else begin
      low_zero_s = 2'd3;
    end
  end

  // Scan / debounce controller next-state logic
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    row_idx_s  = row_idx_r;
    col_idx_s  = col_idx_r;
    key_s      = key;
    pressed_s  = button_pressed;
    col_open_s = col_s[col_idx_r];
    case (state_r)
      SCAN: begin
        if (cnt_r == SCAN_LAST) begin
          cnt_s = CNT_ZERO;
          if (col_s == 4'hF) begin
            row_idx_s = row_idx_r + 2'd1;
          end else begin
            col_idx_s = low_zero_s;
            state_s   = DEB_PRESS;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DEB_PRESS: begin
        if (col_open_s) begin
          // Bounce: rescan the same row from the start of its slot
          state_s = SCAN;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          key_s     = key_code(row_idx_r, col_idx_r);
          pressed_s = 1'b1;
          state_s   = HELD;
          cnt_s     = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        // Only the captured column matters; other keys are ignored here
        if (col_open_s) begin
          state_s = DEB_RELEASE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      DEB_RELEASE: begin
        if (!col_open_s) begin
          // Release bounce: stay pressed so no second rising edge appears
          state_s = HELD;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          pressed_s = 1'b0;
          row_idx_s = row_idx_r + 2'd1;
          state_s   = SCAN;
          cnt_s     = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = SCAN;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // One-cold row pattern for the next row index
  always_comb begin
    row_drive_s = 4'b1110;
    case (row_idx_s)
      2'd0:    row_drive_s = 4'b1110;
      2'd1:    row_drive_s = 4'b1101;
      2'd2:    row_drive_s = 4'b1011;
      2'd3:    row_drive_s = 4'b0111;
      default: row_drive_s = 4'b1110;
    endcase
  end

  // Controller state and registered outputs
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= SCAN;
      cnt_r          <= CNT_ZERO;
      row_idx_r      <= 2'd0;
      col_idx_r      <= 2'd0;
      row_n          <= 4'b1110;
      key            <= 8'd0;
      button_pressed <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      row_idx_r      <= row_idx_s;
      col_idx_r      <= col_idx_s;
      row_n          <= row_drive_s;
      key            <= key_s;
      button_pressed <= pressed_s;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
// A keypad matrix model turns the set of pressed keys into col_n from the
// driven row_n. Expected timing is predicted arithmetically from the scan
// schedule: rows are sampled every SD cycles after the last scan restart,
// columns reach the controller 2 cycles late, and press/release each need
// DEB stable cycles.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 8;

  logic       hwclk = 1'b0;
  logic       reset_n;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [7:0] key;
  logic       button_pressed;
  logic [15:0] keys;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int s_edge = 0;
  int r0     = 0;

  int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB)) dut (
    .hwclk          (hwclk),
    .reset_n        (reset_n),
    .col_n          (col_n),
    .row_n          (row_n),
    .key            (key),
    .button_pressed (button_pressed)
  );

  always #5 hwclk = ~hwclk;

  always @(posedge hwclk) cyc <= cyc + 1;

  // Keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] row_pat(input int r);
    logic [3:0] v;
    v = 4'hF;
    v[r[1:0]] = 1'b0;
    return v;
  endfunction

  // Row being driven at cycle m while scanning with no key found
  function automatic int row_at(input int m);
    return (r0 + (m - s_edge) / SD) % 4;
  endfunction

  // Sample edge at which a key on row r, closed just after edge p, is found
  function automatic int detect_edge(input int r, input int p);
    for (int k = 1; k <= 64; k++) begin
      if (((r0 + k - 1) % 4) == r && (s_edge + k*SD - 2) >= p + 1)
        return s_edge + k*SD;
    end
    return -1;
  endfunction

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge hwclk);
  endtask

  // Expect acceptance of a key on row r closed just after edge p
  task automatic expect_rise(input int r, input int code, input int p);
    int d;
    d = detect_edge(r, p);
    wait_to(d + DEB - 1);
    check("pre_rise_bp", 32'(button_pressed), 32'd0);
    wait_to(d + DEB);
    check("rise_bp", 32'(button_pressed), 32'd1);
    check("rise_key", 32'(key), 32'(code));
    check("rise_row", 32'(row_n), 32'(row_pat(r)));
  endtask

  task automatic do_press(input int r, input logic [3:0] cmask, input int pdly);
    int p, low;
    low = 3;
    for (int c = 3; c >= 0; c--) if (cmask[c]) low = c;
    wait_to(cyc + pdly);
    p = cyc;
    for (int c = 0; c < 4; c++) if (cmask[c]) keys[r*4+c] = 1'b1;
    expect_rise(r, kmap[r*4+low], p);
  endtask

  // Release every key on row r after hold cycles and expect a clean fall
  task automatic do_release(input int r, input int code, input int hold);
    int q;
    q = cyc + hold;
    wait_to(q);
    check("held_row", 32'(row_n), 32'(row_pat(r)));
    for (int c = 0; c < 4; c++) keys[r*4+c] = 1'b0;
    wait_to(q + 3 + DEB - 1);
    check("pre_fall_bp", 32'(button_pressed), 32'd1);
    wait_to(q + 3 + DEB);
    check("fall_bp", 32'(button_pressed), 32'd0);
    check("fall_key_kept", 32'(key), 32'(code));
    s_edge = q + 3 + DEB;
    r0 = (r + 1) % 4;
  endtask

  initial begin
    int p, d, q, r, c;
    reset_n = 1'b0;
    keys    = 16'h0000;
    repeat (3) @(negedge hwclk);
    check("reset_row", 32'(row_n), 32'h0000000E);
    check("reset_key", 32'(key), 32'd0);
    check("reset_bp", 32'(button_pressed), 32'd0);

    // Idle scan rotation
    reset_n = 1'b1;
    s_edge  = cyc;
    r0      = 0;
    for (int m = s_edge; m <= s_edge + 17; m++) begin
      wait_to(m);
      check("scan_row", 32'(row_n), 32'(row_pat(row_at(m))));
    end

    // Key 6 at row1/col2
    do_press(1, 4'b0100, 3);
    do_release(1, 6, 5);

    // Press bounce on row2/col0: closed 5 cycles only
    p = detect_edge(2, cyc) - 3;
    wait_to(p);
    keys[8] = 1'b1;
    d = detect_edge(2, p);
    q = p + 5;
    for (int m = p; m <= d + DEB + 2; m++) begin
      wait_to(m);
      if (m == q) keys[8] = 1'b0;
      check("press_bounce_bp", 32'(button_pressed), 32'd0);
    end
    s_edge = q + 3;
    r0     = 2;
    for (int m = cyc; m <= s_edge + SD + 1; m++) begin
      wait_to(m);
      check("bounce_scan_row", 32'(row_n), 32'(row_pat(row_at(m))));
    end

    // Release bounce on "0" (row3/col1)
    do_press(3, 4'b0010, 2);
    q = cyc + 2;
    wait_to(q);
    keys[13] = 1'b0;
    wait_to(q + 3);
    keys[13] = 1'b1;
    for (int m = q; m <= q + 3 + DEB + 3; m++) begin
      wait_to(m);
      check("rel_bounce_bp", 32'(button_pressed), 32'd1);
    end
    check("rel_bounce_key", 32'(key), 32'd0);
    do_release(3, 0, 4);

    // Two keys on row0: col0 has priority over col3
    do_press(0, 4'b1001, 1);
    q = cyc + 3;
    wait_to(q);
    keys[3] = 1'b0;
    for (int m = q; m <= q + 3 + DEB + 3; m++) begin
      wait_to(m);
      check("col3_release_bp", 32'(button_pressed), 32'd1);
    end
    do_release(0, 1, 2);

    // Asynchronous reset while holding '#'
    do_press(3, 4'b0100, 5);
    reset_n = 1'b0;
    #1;
    check("rst_mid_bp", 32'(button_pressed), 32'd0);
    check("rst_mid_key", 32'(key), 32'd0);
    check("rst_mid_row", 32'(row_n), 32'h0000000E);
    @(negedge hwclk);
    reset_n = 1'b1;
    s_edge  = cyc;
    r0      = 0;
    expect_rise(3, 15, s_edge);
    do_release(3, 15, 3);

    // Randomised single-key presses
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      do_press(r, row_pat(c) ^ 4'hF, $urandom_range(0, 20));
      do_release(r, kmap[r*4+c], $urandom_range(0, 12));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
